instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage sitting directly upstream of the combinational instruction memory.
- Owns the program counter, drives the memory address, and registers the returned instruction with its PC into a one-entry output slot.
- The decode stage consumes the slot through a valid/ready handshake.
- Accepts PC redirects from the branch unit, flushes wrong-path fetches, and halts at the end of the program image.

Parameters:
- RESET_PC, 32'd0, PC loaded on reset.
- PC_LIMIT, 32'd52, first byte address past the program; fetch at pc >= PC_LIMIT enters HALT.
- PC_STEP, 32'd4, sequential increment in bytes.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- imem_addr  output  32  address to instruction memory; combinational copy of pc.
- imem_instr  input  32  instruction word; valid in the same cycle imem_addr is driven.
- redirect_valid  input  1  one-cycle pulse from the branch unit: a taken branch or jump.
- redirect_pc  input  32  target byte address, sampled when redirect_valid=1.
- id_valid  output  1  output slot holds a valid instruction.
- id_instr  output  32  registered instruction word.
- id_pc  output  32  byte address of id_instr.
- id_ready  input  1  decode accepts the slot this cycle.
- halted  output  1  fetch is in HALT and the output slot is empty.

Behaviour:
- Reset is asynchronous on reset_n=0:
  - pc=RESET_PC, state=RUN, id_valid=0, id_instr=0, id_pc=0, halted=0.
  - Release is synchronous; the first fetch occurs on the first rising edge after release.
- imem_addr = pc at all times. The memory is treated as zero-latency, so imem_instr is captured on the same edge.
- Slot free: free = !id_valid | id_ready. A transfer to decode occurs when id_valid & id_ready.
- States:
  - RUN: fetching.
  - HALT: no fetching; pc frozen.
- Per rising edge, in priority order:
  1. redirect_valid=1 (any state):
     - pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
     - id_valid <= 0, flushing any held instruction even if id_ready=1. The handshake does not complete that cycle.
     - state <= RUN; redirect exits HALT.
  2. state=RUN, free=1, pc >= PC_LIMIT:
     - state <= HALT.
     - id_valid <= 0 if the slot was consumed, otherwise unchanged.
     - pc unchanged.
  3. state=RUN, free=1, pc < PC_LIMIT:
     - id_instr <= imem_instr, id_pc <= pc, id_valid <= 1.
     - pc <= pc + PC_STEP, modulo 2^32; wrap from 32'hFFFFFFFC gives 0.
  4. free=0 (stall): pc, id_valid, id_instr, id_pc all hold. No fetch, no state change.
  5. state=HALT, no redirect: id_valid <= 0 once id_ready=1.
- halted = (state==HALT) & !id_valid, registered-derived. It goes high one cycle after the last held instruction is consumed.
- Throughput: one instruction per cycle while id_ready=1. Latency from pc to id_valid is one cycle.
- A redirect arriving during a stall wins: the held instruction is discarded.
- id_instr and id_pc do not change while id_valid=1 and id_ready=0.
- Comparison with PC_LIMIT is unsigned 32-bit.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output fetch_count [31:0] and output flush_count [15:0], both reset to 0 by reset_n.
  - fetch_count increments on each rule-3 fetch.
  - flush_count increments on each redirect that discards id_valid=1.
  - Both counters wrap silently.
- Not defined: no extra ports or registers; behaviour otherwise identical.

Test Plan:
- Reset and run, id_ready=1 constant:
  - imem_addr sequences 0,4,8,…,48.
  - id_pc lags imem_addr by one cycle.
  - After id_pc=48 is consumed, halted=1 on the following cycle and imem_addr stays at 52.
- Stall: id_ready=0 for 3 cycles with id_pc=8 held:
  - id_instr, id_pc and pc=12 remain stable.
  - On release, the next id_pc=12.
- Redirect: redirect_valid pulse with redirect_pc=32'd8 while id_pc=44 is valid:
  - Next cycle id_valid=0 and imem_addr=8.
  - Following cycle id_pc=8.
  - FETCH_PERF_CNT_EN: flush_count=1.
- Redirect from HALT with redirect_pc=32'd20:
  - state returns to RUN, halted=0 next cycle, id_pc=20 one cycle later.
- Misaligned redirect_pc=32'd27 -> pc=24.
- Mid-run async reset:
  - Assert reset_n=0 between clock edges while pc=28.
  - Outputs clear immediately without a clock.
  - After release, fetch restarts at RESET_PC=0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles the fetch stage's bus-side signals: the instruction-memory
//   address/data pair, the branch-unit redirect, and the decode slot
//   handshake.
//   master : the fetch stage (drives imem_addr and the id_* slot, plus halted)
//   slave  : the environment (memory, branch unit, decode)
interface instr_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        halted;

    modport master (
        output imem_addr, id_valid, id_instr, id_pc, halted,
        input  imem_instr, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, id_valid, id_instr, id_pc, halted,
        output imem_instr, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
//   Fetch stage in front of a zero-latency instruction memory. Holds the PC,
//   presents it as imem_addr, and captures {instr, pc} into a one-entry slot
//   consumed by decode through id_valid/id_ready. Branch redirects flush the
//   slot and reload the PC; fetching at or beyond PC_LIMIT enters HALT.
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : instr_fetch_if.master (imem_addr/imem_instr, redirect_valid/
//              redirect_pc, id_valid/id_instr/id_pc/id_ready, halted)
//   fetch_count, flush_count : only when FETCH_PERF_CNT_EN is defined;
//              count slot fills and redirects that discarded a valid slot.
//
// Build option
//   FETCH_PERF_CNT_EN : adds the two performance counters above.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd52,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              reset_n,
    instr_fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [15:0]       flush_count
`endif
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        vld_q, vld_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idpc_q, idpc_d;
    logic        free;
    logic        do_fetch;
    logic        do_flush;

    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = vld_q;
    assign bus.id_instr  = instr_q;
    assign bus.id_pc     = idpc_q;
    assign bus.halted    = (state_q == HALT) && !vld_q;

    assign free = !vld_q || bus.id_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Redirect has top priority in every state; otherwise a free slot in RUN
    // either fetches or, past the image, halts. A full, unaccepted slot
    // stalls everything because the defaults hold all state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        vld_d    = vld_q;
        instr_d  = instr_q;
        idpc_d   = idpc_q;
        do_fetch = 1'b0;
        do_flush = 1'b0;
        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[31:2], 2'b00};
            vld_d    = 1'b0;
            state_d  = RUN;
            do_flush = vld_q;
        end else if (state_q == RUN) begin
            if (free) begin
                if (pc_q >= PC_LIMIT) begin
                    // Free means the slot was empty or is being consumed now.
                    state_d = HALT;
                    vld_d   = 1'b0;
                end else begin
                    instr_d  = bus.imem_instr;
                    idpc_d   = pc_q;
                    vld_d    = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                    do_fetch = 1'b1;
                end
            end
        end else begin
            if (bus.id_ready) vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= 32'd0;
            idpc_q  <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= 32'd0;
            flush_count <= 16'd0;
        end else begin
            if (do_fetch) fetch_count <= fetch_count + 32'd1;
            if (do_flush) flush_count <= flush_count + 16'd1;
        end
    end
`else
    // Strobes only feed the optional counters.
    logic unused_strobes;
    assign unused_strobes = do_fetch ^ do_flush;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: a table of per-cycle vectors plus a
// hand-written mid-run asynchronous reset sequence.
module tb_instr_fetch;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    instr_fetch_if ifc ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] flush_count;
    instr_fetch dut (.clk(clk), .reset_n(reset_n), .bus(ifc.master),
                     .fetch_count(fetch_count), .flush_count(flush_count));
`else
    instr_fetch dut (.clk(clk), .reset_n(reset_n), .bus(ifc.master));
`endif

    // Memory image: each word encodes its own address so a wrong capture shows.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign ifc.imem_instr = mem(ifc.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        eh;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc,
                       input logic [31:0] eaddr, input logic eh);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.eh = eh;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        ifc.redirect_valid = rv;
        ifc.redirect_pc    = rpc;
        ifc.id_ready       = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] eaddr, input logic eh);
        chk({tag, ".id_valid"},  {31'd0, ifc.id_valid}, {31'd0, ev});
        chk({tag, ".imem_addr"}, ifc.imem_addr, eaddr);
        chk({tag, ".halted"},    {31'd0, ifc.halted}, {31'd0, eh});
        if (ev) begin
            chk({tag, ".id_pc"},    ifc.id_pc, epc);
            chk({tag, ".id_instr"}, ifc.id_instr, mem(epc));
        end
    endtask

    initial begin
        int  exp_fetch;
        int  exp_flush;
        logic prev_ev;

        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'd0;
        ifc.id_ready       = 1'b0;

        // Straight run 0..48 with decode always ready, then HALT.
        for (int k = 1; k <= 13; k++) add(0, 0, 1, 1, 32'(4*(k-1)), 32'(4*k), 0);
        add(0, 0,  1, 0, 0, 52, 1);
        add(0, 0,  1, 0, 0, 52, 1);
        // Redirect out of HALT, then a misaligned redirect.
        add(1, 20, 1, 0, 0, 20, 0);
        add(0, 0,  1, 1, 20, 24, 0);
        add(1, 27, 1, 0, 0, 24, 0);
        add(0, 0,  1, 1, 24, 28, 0);
        // Three-cycle stall holding id_pc=8.
        add(1, 8,  1, 0, 0, 8, 0);
        add(0, 0,  1, 1, 8, 12, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 8, 12, 0);
        add(0, 0,  1, 1, 12, 16, 0);
        // Redirect during a stall discards the held instruction.
        add(0, 0,  0, 1, 12, 16, 0);
        add(1, 40, 0, 0, 0, 40, 0);
        add(0, 0,  1, 1, 40, 44, 0);
        add(0, 0,  1, 1, 44, 48, 0);
        // Redirect to 8 while id_pc=44 is valid and being accepted.
        add(1, 8,  1, 0, 0, 8, 0);
        add(0, 0,  1, 1, 8, 12, 0);
        // Last instruction stalled at the limit: HALT waits for consumption.
        add(1, 48, 1, 0, 0, 48, 0);
        add(0, 0,  1, 1, 48, 52, 0);
        add(0, 0,  0, 1, 48, 52, 0);
        add(0, 0,  1, 0, 0, 52, 1);

        #12;
        chk_out("reset", 1'b0, 32'd0, 32'd0, 1'b0);
        chk("reset.id_pc",    ifc.id_pc, 32'd0);
        chk("reset.id_instr", ifc.id_instr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        exp_fetch = 0;
        exp_flush = 0;
        prev_ev   = 1'b0;
        foreach (vq[i]) begin
            step(vq[i].rv, vq[i].rpc, vq[i].rdy);
            chk_out($sformatf("vec%0d", i), vq[i].ev, vq[i].epc, vq[i].eaddr, vq[i].eh);
            if (vq[i].rv && prev_ev) exp_flush++;
            if (!vq[i].rv && vq[i].ev && (!prev_ev || vq[i].rdy)) exp_fetch++;
            prev_ev = vq[i].ev;
        end
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'(exp_fetch));
        chk("flush_count", {16'd0, flush_count}, 32'(exp_flush));
`endif

        // Mid-run asynchronous reset while pc=28.
        step(1, 16, 1);
        chk_out("rst.redir", 1'b0, 32'd0, 32'd16, 1'b0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        chk_out("rst.pre", 1'b1, 32'd24, 32'd28, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 32'd0, 32'd0, 1'b0);
        chk("rst.async.id_pc",    ifc.id_pc, 32'd0);
        chk("rst.async.id_instr", ifc.id_instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst.fetch_count", fetch_count, 32'd0);
        chk("rst.flush_count", {16'd0, flush_count}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 1);
        chk_out("rst.restart0", 1'b1, 32'd0, 32'd4, 1'b0);
        step(0, 0, 1);
        chk_out("rst.restart1", 1'b1, 32'd4, 32'd8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
